// File: rtl/bp_be_late_wb_buffer_pkg.sv
// Shared types for the late writeback buffer: processor config, wb packet, late-wb source id.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bp_be_late_wb_buffer_pkg;

    // Processor configurations known to this slice of the backend.
    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    // Backend writeback packet as produced by the long-latency pipes.
    typedef struct packed {
        logic        ird_w_v;
        logic        frd_w_v;
        logic [4:0]  rd_addr;
        logic [63:0] rd_data;
        logic        fflags_w_v;
        logic [4:0]  fflags;
    } bp_be_wb_pkt_s;

    // Which late source an entry came from; also the arbiter priority state.
    typedef enum logic {
        e_late_wb_int = 1'b0,
        e_late_wb_fp  = 1'b1
    } bp_be_late_wb_src_e;

    // Packet width for a given configuration (all current configs share one layout).
    function automatic int wb_pkt_width_f(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_be_wb_pkt_s);
            default:          return $bits(bp_be_wb_pkt_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_be_late_wb_buffer_fifo.sv
// Small circular FIFO holding late writeback packets; pointers wrap modulo els_p.
// Latency: 1 cycle from enqueue to v_o (no bypass); data_o held until yumi_i.
// Backpressure: ready_o low when full; dequeue is valid-then-yumi.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_wptr;
    logic [ptr_w_lp-1:0] r_rptr;
    logic [ptr_w_lp:0]   r_count;
    logic                w_enq;
    logic                w_deq;

    assign ready_o = (r_count != (ptr_w_lp + 1)'(els_p));
    assign v_o     = (r_count != '0);
    assign data_o  = r_mem[r_rptr];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    // Pointer and occupancy bookkeeping; simultaneous enq/deq leaves count unchanged.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/bp_be_late_wb_buffer.sv
// Merges late integer and FP writebacks into one in-order queue for the scheduler; optional age force under BP_BE_LATE_WB_AGE_FORCE_EN.
// Latency: 1 cycle enqueue to late_wb_v_o; head held stable until late_wb_yumi_i.
// Backpressure: source ready only when granted and not full (independent of same-cycle yumi); force raised when full or head too old.
module bp_be_late_wb_buffer
    import bp_be_late_wb_buffer_pkg::*;
#(
    parameter bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter int         els_p           = 4,
    parameter int         force_age_p     = 16,
    localparam int        wb_pkt_width_lp = wb_pkt_width_f(bp_params_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [wb_pkt_width_lp-1:0] iwb_pkt_i,
    input  logic                       iwb_v_i,
    output logic                       iwb_ready_and_o,

    input  logic [wb_pkt_width_lp-1:0] fwb_pkt_i,
    input  logic                       fwb_v_i,
    output logic                       fwb_ready_and_o,

    output logic [wb_pkt_width_lp-1:0] late_wb_pkt_o,
    output logic                       late_wb_v_o,
    output logic                       late_wb_force_o,
    input  logic                       late_wb_yumi_i,

    output logic                       empty_o
);
    if (els_p < 2 || (els_p & (els_p - 1)) != 0 || force_age_p < 1) begin : g_bad_params
        $error("bp_be_late_wb_buffer: els_p must be a power of two >= 2 and force_age_p >= 1");
    end

    bp_be_late_wb_src_e         r_prio;
    logic                       w_gnt_int;
    logic                       w_gnt_fp;
    logic                       w_fifo_rdy;
    logic                       w_fifo_v;
    logic                       w_enq_v;
    logic [wb_pkt_width_lp-1:0] w_enq_pkt;
    logic                       w_deq;
    logic                       w_age_force;

    // Grant: a lone valid source wins; on contention the priority holder wins.
    always_comb begin
        w_gnt_int = 1'b0;
        w_gnt_fp  = 1'b0;
        if (iwb_v_i && (!fwb_v_i || r_prio == e_late_wb_int)) w_gnt_int = 1'b1;
        if (fwb_v_i && (!iwb_v_i || r_prio == e_late_wb_fp))  w_gnt_fp  = 1'b1;
    end

    assign iwb_ready_and_o = ~reset_i & w_fifo_rdy & w_gnt_int;
    assign fwb_ready_and_o = ~reset_i & w_fifo_rdy & w_gnt_fp;
    assign w_enq_v         = iwb_ready_and_o | fwb_ready_and_o;
    assign w_enq_pkt       = iwb_ready_and_o ? iwb_pkt_i : fwb_pkt_i;
    assign w_deq           = late_wb_yumi_i & w_fifo_v;

    // Round-robin: a contended transfer hands priority to the loser.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_prio <= e_late_wb_int;
        end else if (iwb_v_i && fwb_v_i && w_enq_v) begin
            r_prio <= iwb_ready_and_o ? e_late_wb_fp : e_late_wb_int;
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (wb_pkt_width_lp),
        .els_p   (els_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_enq_v),
        .data_i  (w_enq_pkt),
        .ready_o (w_fifo_rdy),
        .v_o     (w_fifo_v),
        .data_o  (late_wb_pkt_o),
        .yumi_i  (w_deq)
    );

`ifdef BP_BE_LATE_WB_AGE_FORCE_EN
    localparam int age_w_lp = $clog2(force_age_p + 1);
    logic [age_w_lp-1:0] r_age;

    // Cycles the current head has waited; restarts per head and saturates.
    always_ff @(posedge clk_i) begin
        if (reset_i || w_deq || !w_fifo_v) begin
            r_age <= '0;
        end else if (r_age != age_w_lp'(force_age_p)) begin
            r_age <= r_age + 1'b1;
        end
    end

    assign w_age_force = (r_age >= age_w_lp'(force_age_p));
`else
    assign w_age_force = 1'b0;
`endif

    assign late_wb_v_o     = ~reset_i & w_fifo_v;
    assign late_wb_force_o = ~reset_i & (~w_fifo_rdy | w_age_force);
    assign empty_o         = ~late_wb_v_o;

    // A yumi must only ever consume a presented head.
    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!late_wb_yumi_i || w_fifo_v);
    end

endmodule

// File: tb/tb_bp_be_late_wb_buffer.sv
module tb_bp_be_late_wb_buffer;
    import bp_be_late_wb_buffer_pkg::*;

    localparam int ELS = 4;
    localparam int AGE = 16;

    logic clk = 1'b0;
    logic reset_i;
    bp_be_wb_pkt_s iwb_pkt, fwb_pkt, out_pkt;
    logic iwb_v, fwb_v, iwb_rdy, fwb_rdy, out_v, out_force, yumi, empty;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bp_be_late_wb_buffer #(.els_p(ELS), .force_age_p(AGE)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .iwb_pkt_i       (iwb_pkt),
        .iwb_v_i         (iwb_v),
        .iwb_ready_and_o (iwb_rdy),
        .fwb_pkt_i       (fwb_pkt),
        .fwb_v_i         (fwb_v),
        .fwb_ready_and_o (fwb_rdy),
        .late_wb_pkt_o   (out_pkt),
        .late_wb_v_o     (out_v),
        .late_wb_force_o (out_force),
        .late_wb_yumi_i  (yumi),
        .empty_o         (empty)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bp_be_wb_pkt_s mk(input logic [4:0] rd, input logic fp);
        bp_be_wb_pkt_s p;
        p = '0;
        p.ird_w_v = ~fp;
        p.frd_w_v = fp;
        p.rd_addr = rd;
        p.rd_data = {32'hA5A5_0000, 27'd0, rd};
        return p;
    endfunction

    function automatic bp_be_wb_pkt_s rnd_pkt();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return bp_be_wb_pkt_s'(r[76:0]);
    endfunction

    task automatic idle_inputs();
        iwb_v = 0; fwb_v = 0; yumi = 0;
        iwb_pkt = '0; fwb_pkt = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle_inputs();
        iwb_v = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_v", out_v, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_force", out_force, 1'b0);
        check("rst_irdy", iwb_rdy, 1'b0);
        check("rst_frdy", fwb_rdy, 1'b0);
        reset_i = 1'b0;
        iwb_v = 1'b0;
    endtask

    typedef struct packed {
        logic       iv, fv, y;
        logic [4:0] ird, frd;
        logic       e_irdy, e_frdy, e_v, e_force, e_empty;
        logic [4:0] e_rd;
    } vec_t;

    vec_t tbl [15];

    // Reference model state
    bp_be_wb_pkt_s q[$];
    int  m_prio;
    int  m_age;

    initial begin
        reset_i = 1'b1;
        idle_inputs();

        //          iv fv y  ird frd  irdy frdy v  force empty rd
        tbl[0]  = '{1, 0, 0, 5,  0,   1,   0,   0, 0,    1,    0};
        tbl[1]  = '{0, 0, 1, 0,  0,   0,   0,   1, 0,    0,    5};
        tbl[2]  = '{0, 0, 0, 0,  0,   0,   0,   0, 0,    1,    0};
        tbl[3]  = '{1, 1, 0, 10, 20,  1,   0,   0, 0,    1,    0};
        tbl[4]  = '{1, 1, 0, 11, 20,  0,   1,   1, 0,    0,    10};
        tbl[5]  = '{1, 1, 0, 11, 21,  1,   0,   1, 0,    0,    10};
        tbl[6]  = '{1, 1, 0, 12, 21,  0,   1,   1, 0,    0,    10};
        tbl[7]  = '{1, 1, 0, 12, 22,  0,   0,   1, 1,    0,    10};
        tbl[8]  = '{1, 0, 1, 12, 0,   0,   0,   1, 1,    0,    10};
        tbl[9]  = '{1, 0, 0, 12, 0,   1,   0,   1, 0,    0,    20};
        tbl[10] = '{0, 0, 1, 0,  0,   0,   0,   1, 1,    0,    20};
        tbl[11] = '{0, 0, 1, 0,  0,   0,   0,   1, 0,    0,    11};
        tbl[12] = '{0, 0, 1, 0,  0,   0,   0,   1, 0,    0,    21};
        tbl[13] = '{0, 0, 1, 0,  0,   0,   0,   1, 0,    0,    12};
        tbl[14] = '{0, 0, 0, 0,  0,   0,   0,   0, 0,    1,    0};

        do_reset();

        // Directed vectors: first enqueue, contended fill, full with same-cycle yumi, drain.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            iwb_v = tbl[i].iv;  iwb_pkt = mk(tbl[i].ird, 1'b0);
            fwb_v = tbl[i].fv;  fwb_pkt = mk(tbl[i].frd, 1'b1);
            yumi  = tbl[i].y;
            #1;
            check($sformatf("tbl%0d_irdy", i), iwb_rdy, tbl[i].e_irdy);
            check($sformatf("tbl%0d_frdy", i), fwb_rdy, tbl[i].e_frdy);
            check($sformatf("tbl%0d_v", i), out_v, tbl[i].e_v);
            check($sformatf("tbl%0d_force", i), out_force, tbl[i].e_force);
            check($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
            if (tbl[i].e_v) check($sformatf("tbl%0d_rd", i), out_pkt.rd_addr, tbl[i].e_rd);
        end

        // Single entry left waiting: force only from age, and only when built.
        @(negedge clk);
        idle_inputs();
        iwb_v = 1; iwb_pkt = mk(5'd7, 1'b0);
        #1;
        check("age_enq_rdy", iwb_rdy, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            check($sformatf("age%0d_v", k), out_v, 1'b1);
`ifdef BP_BE_LATE_WB_AGE_FORCE_EN
            check($sformatf("age%0d_force", k), out_force, (k - 1) >= AGE);
`else
            check($sformatf("age%0d_force", k), out_force, 1'b0);
`endif
            if (k == 17) yumi = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("age_after_force", out_force, 1'b0);
        check("age_after_empty", empty, 1'b1);

        // Mid-operation reset with 3 entries and priority on the FP side.
        @(negedge clk);
        iwb_v = 1; iwb_pkt = mk(5'd1, 1'b0); fwb_v = 1; fwb_pkt = mk(5'd2, 1'b1);
        #1;
        check("mr_gnt_int", iwb_rdy, 1'b1);
        check("mr_no_fp", fwb_rdy, 1'b0);
        @(negedge clk);
        fwb_v = 0; iwb_pkt = mk(5'd3, 1'b0);
        @(negedge clk);
        iwb_pkt = mk(5'd4, 1'b0);
        @(negedge clk);
        iwb_v = 0;
        #1;
        check("mr_v_before", out_v, 1'b1);
        @(negedge clk);
        reset_i = 1; iwb_v = 1; fwb_v = 1;
        iwb_pkt = mk(5'd5, 1'b0); fwb_pkt = mk(5'd6, 1'b1);
        #1;
        check("mr_rst_irdy", iwb_rdy, 1'b0);
        check("mr_rst_frdy", fwb_rdy, 1'b0);
        @(negedge clk);
        reset_i = 0;
        #1;
        check("mr_v_after", out_v, 1'b0);
        check("mr_empty_after", empty, 1'b1);
        check("mr_prio_int", iwb_rdy, 1'b1);
        check("mr_prio_fp_lose", fwb_rdy, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mr_head", out_pkt, mk(5'd5, 1'b0));
        yumi = out_v;

        // Randomized run against a queue-based model.
        do_reset();
        q.delete();
        m_prio = 0;
        m_age = 0;
        for (int c = 0; c < 4000; c++) begin
            int  yp;
            bit  full, gi, gf, ef;
            @(negedge clk);
            yp = ((c / 400) % 2 == 0) ? 10 : 60;
            iwb_v = ($urandom_range(0, 99) < 55);
            fwb_v = ($urandom_range(0, 99) < 45);
            iwb_pkt = rnd_pkt();
            fwb_pkt = rnd_pkt();
            yumi = (q.size() > 0) && ($urandom_range(0, 99) < yp);
            full = (q.size() == ELS);
            gi = iwb_v && (!fwb_v || m_prio == 0) && !full;
            gf = fwb_v && (!iwb_v || m_prio == 1) && !full;
            ef = full;
`ifdef BP_BE_LATE_WB_AGE_FORCE_EN
            ef = ef || (m_age >= AGE);
`endif
            #1;
            check("rnd_irdy", iwb_rdy, gi);
            check("rnd_frdy", fwb_rdy, gf);
            check("rnd_v", out_v, q.size() > 0);
            check("rnd_empty", empty, q.size() == 0);
            check("rnd_force", out_force, ef);
            if (q.size() > 0) check("rnd_head", out_pkt, q[0]);

            if (q.size() == 0 || yumi) m_age = 0;
            else if (m_age < AGE) m_age++;
            if (yumi) void'(q.pop_front());
            if (gi) q.push_back(iwb_pkt);
            if (gf) q.push_back(fwb_pkt);
            if (iwb_v && fwb_v && (gi || gf)) m_prio = gi ? 1 : 0;
        end

        @(negedge clk);
        idle_inputs();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
